// File: rtl/pistorm_pkg.sv
// Shared constants and the queued bus-operation payload for the Pi-side
// transaction queue.
package pistorm_pkg;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REGA_W  = 2;

  localparam logic [REGA_W-1:0] REG_DATA    = 2'd0;
  localparam logic [REGA_W-1:0] REG_ADDR_LO = 2'd1;
  localparam logic [REGA_W-1:0] REG_ADDR_HI = 2'd2;
  localparam logic [REGA_W-1:0] REG_STATUS  = 2'd3;

  localparam int unsigned STS_OVF  = 15;
  localparam int unsigned STS_RDV  = 14;
  localparam int unsigned STS_BUSY = 13;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw;
    logic              uds_n;
    logic              lds_n;
  } txn_t;

  localparam int unsigned TXN_W = $bits(txn_t);

endpackage

// File: rtl/pistorm_txn_queue_if.sv
// Pi register port plus sequencer operation handshake of the transaction queue.
interface pistorm_txn_queue_if;
  import pistorm_pkg::*;

  logic              reg_wr;
  logic              reg_rd;
  logic [REGA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_wdata;

  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_rw;
  logic              op_uds_n;
  logic              op_lds_n;
  logic              op_done;
  logic [DATA_W-1:0] op_rdata;

  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic [DATA_W-1:0] status_word;

  modport slave (
    input  reg_wr, reg_rd, reg_a, reg_wdata, op_ready, op_done, op_rdata,
    output op_valid, op_addr, op_wdata, op_rw, op_uds_n, op_lds_n,
           rd_data, busy, status_word
  );

  modport master (
    output reg_wr, reg_rd, reg_a, reg_wdata, op_ready, op_done, op_rdata,
    input  op_valid, op_addr, op_wdata, op_rw, op_uds_n, op_lds_n,
           rd_data, busy, status_word
  );

endinterface

// File: rtl/pistorm_sync_fifo.sv
// Single-clock FIFO with combinational head read and an occupancy count
// that distinguishes full from empty via one extra pointer bit.
module pistorm_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata_c,
  output logic          full_c,
  output logic [AW:0]   count
);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata_c = mem[rd_ptr[AW-1:0]];
  assign full_c  = (count == CW'(DEPTH));

endmodule

// File: rtl/pistorm_txn_queue.sv
// Pi-side transaction queue: assembles DATA/ADDR_LO/ADDR_HI register writes
// into 68k bus operations and issues them to the sequencer one at a time.
module pistorm_txn_queue
  import pistorm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic               PI_CLK,
  input  logic               PI_RST_n,
  pistorm_txn_queue_if.slave bus
);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_hold, data_hold_nxt;
  logic [DATA_W-1:0] addr_lo_hold, addr_lo_hold_nxt;
  logic [DATA_W-1:0] rd_data_q, rd_data_nxt;
  logic              rd_valid, rd_valid_nxt;
  logic              ovf, ovf_nxt;
  logic              outstanding, outstanding_nxt;
  logic              out_rw, out_rw_nxt;
  logic              op_valid_q, op_valid_nxt;
  logic              busy_q, busy_nxt;
  logic [CNT_W-1:0]  count_nxt;

  logic              wr_data, wr_addr_lo, wr_addr_hi, wr_status, rd_data_strobe;
  logic              pop, push_ok, full_c;
  logic [CNT_W-1:0]  count;
  logic [TXN_W-1:0]  head_bits;
  txn_t              push_txn, head;
  logic [DATA_W-1:0] status_c;

  assign wr_data        = bus.reg_wr && (bus.reg_a == REG_DATA);
  assign wr_addr_lo     = bus.reg_wr && (bus.reg_a == REG_ADDR_LO);
  assign wr_addr_hi     = bus.reg_wr && (bus.reg_a == REG_ADDR_HI);
  assign wr_status      = bus.reg_wr && (bus.reg_a == REG_STATUS);
  assign rd_data_strobe = bus.reg_rd && (bus.reg_a == REG_DATA);

  // A pop frees the slot in the same cycle, so a full queue still accepts.
  assign pop     = op_valid_q && bus.op_ready;
  assign push_ok = wr_addr_hi && (!full_c || pop);

  // Entry assembled from the ADDR_HI write and the held DATA/ADDR_LO values.
  always_comb begin
    push_txn       = '0;
    push_txn.addr  = {bus.reg_wdata[7:0], addr_lo_hold};
    push_txn.wdata = data_hold;
    push_txn.rw    = bus.reg_wdata[9];
    push_txn.uds_n = bus.reg_wdata[8] &  addr_lo_hold[0];
    push_txn.lds_n = bus.reg_wdata[8] & ~addr_lo_hold[0];
  end

  pistorm_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (TXN_W),
    .AW    (PTR_W)
  ) u_fifo (
    .clk     (PI_CLK),
    .rst_n   (PI_RST_n),
    .push    (push_ok),
    .pop     (pop),
    .wdata   (push_txn),
    .rdata_c (head_bits),
    .full_c  (full_c),
    .count   (count)
  );

  assign head = txn_t'(head_bits);

  // Next-state for holds, completion tracking and status flags.
  always_comb begin
    data_hold_nxt    = data_hold;
    addr_lo_hold_nxt = addr_lo_hold;
    rd_data_nxt      = rd_data_q;
    rd_valid_nxt     = rd_valid;
    ovf_nxt          = ovf;
    outstanding_nxt  = outstanding;
    out_rw_nxt       = out_rw;

    if (wr_data)    data_hold_nxt    = bus.reg_wdata;
    if (wr_addr_lo) addr_lo_hold_nxt = bus.reg_wdata;

    // Clear first so a completing read in the same cycle wins.
    if (rd_data_strobe) rd_valid_nxt = 1'b0;
    if (bus.op_done && outstanding) begin
      outstanding_nxt = 1'b0;
      if (out_rw) begin
        rd_valid_nxt = 1'b1;
        rd_data_nxt  = bus.op_rdata;
      end
    end
    if (pop) begin
      outstanding_nxt = 1'b1;
      out_rw_nxt      = head.rw;
    end

    // Overflow set takes priority over a software clear.
    if (wr_status && bus.reg_wdata[STS_OVF]) ovf_nxt = 1'b0;
    if (wr_addr_hi && !push_ok)              ovf_nxt = 1'b1;

    count_nxt    = count + CNT_W'(push_ok) - CNT_W'(pop);
    op_valid_nxt = (count_nxt != '0) && !outstanding_nxt;
    busy_nxt     = (count_nxt != '0) || outstanding_nxt;
  end

  always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
    if (!PI_RST_n) begin
      data_hold    <= '0;
      addr_lo_hold <= '0;
      rd_data_q    <= '0;
      rd_valid     <= 1'b0;
      ovf          <= 1'b0;
      outstanding  <= 1'b0;
      out_rw       <= 1'b0;
      op_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_hold    <= data_hold_nxt;
      addr_lo_hold <= addr_lo_hold_nxt;
      rd_data_q    <= rd_data_nxt;
      rd_valid     <= rd_valid_nxt;
      ovf          <= ovf_nxt;
      outstanding  <= outstanding_nxt;
      out_rw       <= out_rw_nxt;
      op_valid_q   <= op_valid_nxt;
      busy_q       <= busy_nxt;
    end
  end

  always_comb begin
    status_c           = '0;
    status_c[STS_OVF]  = ovf;
    status_c[STS_RDV]  = rd_valid;
    status_c[STS_BUSY] = busy_q;
    status_c[4:0]      = 5'(count);
  end

  assign bus.op_valid    = op_valid_q;
  assign bus.op_addr     = head.addr;
  assign bus.op_wdata    = head.wdata;
  assign bus.op_rw       = head.rw;
  assign bus.op_uds_n    = head.uds_n;
  assign bus.op_lds_n    = head.lds_n;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;
  assign bus.status_word = status_c;

endmodule

// File: tb/tb_pistorm_txn_queue.sv
// Scoreboard bench for pistorm_txn_queue: expected operations are queued at
// each ADDR_HI write and compared when the DUT presents them.
module tb_pistorm_txn_queue;
  import pistorm_pkg::*;

  localparam int DEPTH = 4;

  logic PI_CLK   = 1'b0;
  logic PI_RST_n = 1'b0;

  pistorm_txn_queue_if bus();

  pistorm_txn_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .PI_CLK   (PI_CLK),
    .PI_RST_n (PI_RST_n),
    .bus      (bus)
  );

  always #5 PI_CLK = ~PI_CLK;

  int n_checks = 0;
  int n_errors = 0;

  txn_t        q[$];
  logic [15:0] m_data, m_lo, m_rd;
  int          m_cnt;
  logic        m_ovf, m_rdv, m_out, m_out_rw;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0; m_lo = '0; m_rd = '0; m_cnt = 0;
    m_ovf = 1'b0; m_rdv = 1'b0; m_out = 1'b0; m_out_rw = 1'b0;
  endtask

  function automatic logic [15:0] exp_status();
    return {m_ovf, m_rdv, (m_cnt != 0) || m_out, 8'd0, 5'(m_cnt)};
  endfunction

  function automatic txn_t mk_txn(input logic [15:0] hi);
    txn_t t;
    t.addr  = {hi[7:0], m_lo};
    t.wdata = m_data;
    t.rw    = hi[9];
    t.uds_n = hi[8] ? m_lo[0]  : 1'b0;
    t.lds_n = hi[8] ? ~m_lo[0] : 1'b0;
    return t;
  endfunction

  task automatic cyc();
    @(posedge PI_CLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_a = '0; bus.reg_wdata = '0;
    bus.op_ready = 1'b0; bus.op_done = 1'b0; bus.op_rdata = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    case (a)
      REG_DATA:    m_data = d;
      REG_ADDR_LO: m_lo = d;
      REG_ADDR_HI: begin
        if (m_cnt < DEPTH) begin q.push_back(mk_txn(d)); m_cnt++; end
        else m_ovf = 1'b1;
      end
      default: if (d[15]) m_ovf = 1'b0;
    endcase
    bus.reg_wr = 1'b1; bus.reg_a = a; bus.reg_wdata = d;
    cyc();
    bus.reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    if (a == REG_DATA) m_rdv = 1'b0;
    bus.reg_rd = 1'b1; bus.reg_a = a;
    cyc();
    bus.reg_rd = 1'b0;
  endtask

  task automatic push_op(input logic [15:0] data, input logic [15:0] lo, input logic [15:0] hi);
    wr(REG_DATA, data);
    wr(REG_ADDR_LO, lo);
    wr(REG_ADDR_HI, hi);
  endtask

  // Wait (bounded) for a head operation, score it and accept it.
  task automatic issue();
    txn_t e;
    int n = 0;
    while (!bus.op_valid && n < 20) begin cyc(); n++; end
    check_eq("issue_valid", bus.op_valid, 1'b1);
    if (bus.op_valid) begin
      if (q.size() == 0) begin
        check_eq("unexpected_op", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check_eq("head_txn", {bus.op_addr, bus.op_wdata, bus.op_rw, bus.op_uds_n, bus.op_lds_n}, e);
        m_cnt--; m_out = 1'b1; m_out_rw = e.rw;
      end
      bus.op_ready = 1'b1;
      cyc();
      bus.op_ready = 1'b0;
      check_eq("valid_drop_after_pop", bus.op_valid, 1'b0);
    end
  endtask

  task automatic complete(input logic [15:0] rdata);
    if (m_out && m_out_rw) begin m_rdv = 1'b1; m_rd = rdata; end
    m_out = 1'b0;
    bus.op_done = 1'b1; bus.op_rdata = rdata;
    cyc();
    bus.op_done = 1'b0;
    check_eq("rd_data", bus.rd_data, m_rd);
    check_eq("status_after_done", bus.status_word, exp_status());
    check_eq("valid_after_done", bus.op_valid, m_cnt != 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      issue();
      complete(16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t        e;
    logic [15:0] hi;
    drive_idle();
    model_reset();

    // Reset state, while held and after release
    #3;
    check_eq("rst_op_valid", bus.op_valid, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_status", bus.status_word, 16'h0);
    check_eq("rst_rd_data", bus.rd_data, 16'h0);
    repeat (2) cyc();
    PI_RST_n = 1'b1;
    cyc();
    check_eq("post_rst_status", bus.status_word, 16'h0);

    // Single word write: one-cycle latency to op_valid
    push_op(16'hBEEF, 16'h1234, 16'h0012);
    check_eq("t1_valid", bus.op_valid, 1'b1);
    check_eq("t1_addr", bus.op_addr, 24'h121234);
    check_eq("t1_wdata", bus.op_wdata, 16'hBEEF);
    check_eq("t1_ctl", {bus.op_rw, bus.op_uds_n, bus.op_lds_n}, 3'b000);
    check_eq("t1_status", bus.status_word, exp_status());
    issue();
    complete(16'h0);

    // Byte read at odd address
    wr(REG_ADDR_LO, 16'h0001);
    wr(REG_ADDR_HI, 16'h0300);
    check_eq("t2_ctl", {bus.op_rw, bus.op_uds_n, bus.op_lds_n}, 3'b110);
    issue();
    complete(16'h00A5);
    check_eq("t2_rd_data", bus.rd_data, 16'h00A5);
    check_eq("t2_rdv_set", bus.status_word[14], 1'b1);
    rd(REG_DATA);
    check_eq("t2_rdv_clear", bus.status_word[14], 1'b0);

    // Overflow: five pushes into a four-deep queue
    for (int i = 1; i <= 5; i++) push_op(16'(i * 16'h111), 16'(i), 16'h0000);
    check_eq("t3_count", bus.status_word[4:0], 5'd4);
    check_eq("t3_ovf", bus.status_word[15], 1'b1);
    check_eq("t3_status", bus.status_word, exp_status());
    drain();
    repeat (3) cyc();
    check_eq("t3_fifth_absent", bus.op_valid, 1'b0);
    check_eq("t3_idle", bus.busy, 1'b0);
    wr(REG_STATUS, 16'h8000);
    check_eq("t3_ovf_clear", bus.status_word[15], 1'b0);

    // Push into a full queue in the same cycle as a pop
    for (int i = 0; i < 4; i++) push_op(16'h2000 + 16'(i), 16'h0010 + 16'(i), 16'h0000);
    wr(REG_ADDR_LO, 16'h0055);
    check_eq("t4_full", bus.status_word[4:0], 5'd4);
    e = q.pop_front();
    check_eq("t4_head", {bus.op_addr, bus.op_wdata, bus.op_rw, bus.op_uds_n, bus.op_lds_n}, e);
    m_cnt--; m_out = 1'b1; m_out_rw = e.rw;
    hi = 16'h0001;
    q.push_back(mk_txn(hi)); m_cnt++;
    bus.op_ready = 1'b1;
    bus.reg_wr = 1'b1; bus.reg_a = REG_ADDR_HI; bus.reg_wdata = hi;
    cyc();
    bus.op_ready = 1'b0; bus.reg_wr = 1'b0;
    check_eq("t4_no_ovf", bus.status_word[15], 1'b0);
    check_eq("t4_count", bus.status_word[4:0], 5'd4);
    check_eq("t4_valid_drop", bus.op_valid, 1'b0);
    check_eq("t4_status", bus.status_word, exp_status());
    complete(16'h0);
    drain();

    // Reset while an operation is outstanding with two queued
    push_op(16'h1111, 16'h0100, 16'h0200);
    push_op(16'h2222, 16'h0102, 16'h0000);
    push_op(16'h3333, 16'h0104, 16'h0000);
    issue();
    check_eq("t5_pre_count", bus.status_word[4:0], 5'd2);
    PI_RST_n = 1'b0;
    #1;
    check_eq("t5_busy", bus.busy, 1'b0);
    check_eq("t5_valid", bus.op_valid, 1'b0);
    check_eq("t5_count", bus.status_word[4:0], 5'd0);
    model_reset();
    cyc();
    PI_RST_n = 1'b1;
    cyc();
    bus.op_done = 1'b1; bus.op_rdata = 16'h5A5A;
    cyc();
    bus.op_done = 1'b0;
    check_eq("t5_late_done_rdv", bus.status_word[14], 1'b0);
    check_eq("t5_late_done_data", bus.rd_data, 16'h0);

    // Read completion collides with a DATA read: set wins
    push_op(16'h0, 16'h0002, 16'h0200);
    issue();
    m_rdv = 1'b1; m_rd = 16'h1357; m_out = 1'b0;
    bus.op_done = 1'b1; bus.op_rdata = 16'h1357;
    bus.reg_rd = 1'b1; bus.reg_a = REG_DATA;
    cyc();
    bus.op_done = 1'b0; bus.reg_rd = 1'b0;
    check_eq("t6_rdv", bus.status_word[14], 1'b1);
    check_eq("t6_rd_data", bus.rd_data, 16'h1357);
    rd(REG_DATA);

    // Mixed random operations, one at a time
    for (int i = 0; i < 6; i++) begin
      hi = {6'd0, 1'($urandom), 1'($urandom), 8'($urandom)};
      push_op(16'($urandom), 16'($urandom), hi);
      issue();
      complete(16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pistorm_txn_queue.md
Name: pistorm_txn_queue

Overview:
- Upstream feeder for the 68k bus sequencer, in the PI_CLK domain.
- Assembles Pi register writes (DATA, ADDR_LO, ADDR_HI) into complete bus operations and buffers them in a small FIFO.
- Issues operations to the sequencer over a valid/ready handshake, one outstanding at a time.
- Captures returned read data and exposes busy/overflow/read-valid status, so the Pi can post writes back-to-back without polling per transaction.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width, with one extra bit used for the full/empty distinction.

Ports:
- PI_CLK  in  1  single clock (200 MHz Pi-side clock).
- PI_RST_n  in  1  asynchronous active-low reset.
- reg_wr  in  1  one-cycle pulse: already-synchronised Pi register write.
- reg_rd  in  1  one-cycle pulse: already-synchronised Pi register read.
- reg_a  in  2  register select: 0=DATA, 1=ADDR_LO, 2=ADDR_HI, 3=STATUS.
- reg_wdata  in  16  Pi write data.
- op_valid  out  1  FIFO head operation available.
- op_ready  in  1  one-cycle pulse: sequencer accepted the head operation.
- op_addr  out  24  byte address of the head entry.
- op_wdata  out  16  write data of the head entry.
- op_rw  out  1  1=read, 0=write.
- op_uds_n  out  1  upper data strobe, active low.
- op_lds_n  out  1  lower data strobe, active low.
- op_done  in  1  one-cycle pulse: sequencer finished the operation (S7).
- op_rdata  in  16  read data, valid with op_done.
- rd_data  out  16  last captured read data.
- busy  out  1  FIFO non-empty or an operation is outstanding.
- status_word  out  16  {ovf, rd_valid, busy, 8'd0, count[4:0]}, with count zero-extended.

Behaviour:
- Reset (asynchronous, PI_RST_n low):
  - pointers, count, outstanding, rd_valid, ovf = 0.
  - data_hold, addr_lo_hold, rd_data = 0.
  - op_valid=0, busy=0.
  - Outputs are valid in the cycle following reset deassertion.
- reg_wr, reg_a=DATA: data_hold <= reg_wdata.
- reg_wr, reg_a=ADDR_LO: addr_lo_hold <= reg_wdata.
- reg_wr, reg_a=ADDR_HI pushes one entry:
  - addr = {reg_wdata[7:0], addr_lo_hold}.
  - wdata = data_hold.
  - rw = reg_wdata[9].
  - Byte strobes: if reg_wdata[8]=1 (byte access), uds_n = addr[0] and lds_n = !addr[0]; otherwise both are 0.
- Push acceptance:
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and ovf <= 1 (sticky).
- reg_wr, reg_a=STATUS, reg_wdata[15]=1: ovf <= 0.
  - An overflow event in the same cycle wins: ovf stays 1.
- Pop and outstanding tracking:
  - op_valid = (count!=0) && !outstanding, registered from the current count/outstanding state.
  - Head fields are driven combinationally from FIFO storage at the read pointer.
  - Pop occurs when op_valid && op_ready: read pointer advances, outstanding <= 1, out_rw <= head rw.
  - op_ready while op_valid=0 is ignored.
- Completion:
  - op_done while outstanding=1: outstanding <= 0.
  - If out_rw=1, also rd_data <= op_rdata and rd_valid <= 1.
  - op_done while outstanding=0 is ignored.
- reg_rd, reg_a=DATA: rd_valid <= 0.
  - If op_done with a read completes in the same cycle, set wins and rd_valid stays 1.
- Latency:
  - ADDR_HI write to op_valid high: 1 cycle when the queue is empty and idle.
  - op_done to next op_valid: 1 cycle if entries remain.
- busy = (count!=0) || outstanding.
- count is DEPTH+1 states wide. Pointers wrap modulo DEPTH, and the extra pointer bit toggles on wrap.
- FIFO ordering is strict, reads included. A read's data is ready when rd_valid=1.
- No mid-transaction abort. Reset during an outstanding operation drops it; the sequencer's later op_done is ignored because outstanding=0.

Decomposition:
- Package pistorm_pkg:
  - register select constants REG_DATA/REG_ADDR_LO/REG_ADDR_HI/REG_STATUS.
  - status bit indices STS_OVF=15, STS_RDV=14, STS_BUSY=13.
  - txn entry struct {addr[23:0], wdata[15:0], rw, uds_n, lds_n} (43 bits).
- One sub-module: pistorm_sync_fifo (parameterised DEPTH/width).
  - push/pop/full/empty/count.
  - Combinational head read.
  - Asynchronous active-low reset.

Test Plan:
- Write DATA=0xBEEF, ADDR_LO=0x1234, ADDR_HI=0x0012 -> next cycle op_valid=1, op_addr=0x121234, op_wdata=0xBEEF, op_rw=0, uds_n=0, lds_n=0.
- Byte read: ADDR_LO=0x0001, ADDR_HI=0x0300, then op_ready, then op_done with op_rdata=0x00A5:
  - head shows op_rw=1, uds_n=1, lds_n=0.
  - rd_data=0x00A5 and status_word[14]=1.
  - reg_rd of DATA clears status_word[14].
- Push 5 writes with op_ready held low (DEPTH=4):
  - count=4 and status_word[15]=1.
  - Draining shows addresses 1..4 in order; the 5th is absent.
  - STATUS write of 0x8000 clears ovf.
- With count=4, issue an ADDR_HI push in the same cycle as op_ready:
  - push is accepted, ovf stays 0, count stays 4.
  - outstanding=1 and op_valid drops the next cycle.
- Assert PI_RST_n low while outstanding=1 with 2 entries queued:
  - immediately busy=0, op_valid=0, count=0.
  - A subsequent op_done pulse leaves rd_valid=0.
- op_done with a read in the same cycle as reg_rd of DATA: rd_valid=1 and rd_data updated.
